// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller for a 5-stage in-order core.
// Optional: define PIPE_FWD_EN when the datapath forwards (load-use stalls only).
module pipe_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dreq,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_halt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regWrite,
    input  logic        ex_dren,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regWrite,
    input  logic        mem_pcsrc,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        memwb_flush,
    output logic        halt,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        halt_q;
    logic [15:0] cnt_q, cnt_d;

    logic hazard;
    logic mem_wait;
    logic active;
    logic ev_rst;
    logic ev_halted;
    logic ev_mwait;
    logic ev_branch;
    logic ev_hazard;
    logic ev_idle;

    // Does a writer with destination rd feed a source the decode stage reads?
    function automatic logic rd_hits(input logic [4:0] rd);
        rd_hits = (rd != 5'd0) &&
                  ((rd == id_rs) || (id_uses_rt && (rd == id_rt)));
    endfunction

`ifdef PIPE_FWD_EN
    // Forwarding covers everything except a load result needed next cycle.
    always_comb begin
        hazard = ex_dren && ex_regWrite && rd_hits(ex_rd);
    end

    logic unused_ok;
    assign unused_ok = ^{mem_rd, mem_regWrite};
`else
    // No forwarding: wait until both in-flight writers reach WB.
    always_comb begin
        hazard = (ex_regWrite && rd_hits(ex_rd)) ||
                 (mem_regWrite && rd_hits(mem_rd));
    end

    logic unused_ok;
    assign unused_ok = ex_dren;
`endif

    assign mem_wait  = mem_dreq && !dhit;
    assign active    = !RST && (state_q != S_HALTED);

    // One-hot event decode in priority order.
    assign ev_rst    = RST;
    assign ev_halted = !RST && (state_q == S_HALTED);
    assign ev_mwait  = active && mem_wait;
    assign ev_branch = active && !mem_wait && mem_pcsrc;
    assign ev_hazard = active && !mem_wait && !mem_pcsrc && hazard;
    assign ev_idle   = active && !mem_wait && !mem_pcsrc && !hazard;

    // Combinational enables/flushes from state and the current event.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        unique case (1'b1)
            ev_rst: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                ifid_flush  = 1'b1;
                idex_en     = 1'b0;
                idex_flush  = 1'b1;
                exmem_en    = 1'b0;
                exmem_flush = 1'b1;
                memwb_en    = 1'b0;
                memwb_flush = 1'b1;
            end
            ev_halted: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            ev_mwait: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end
            ev_branch: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            ev_hazard: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            ev_idle: begin
                if (!ihit) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        endcase
        // While draining, fetch stays parked and only bubbles enter decode,
        // unless an older taken branch redirects the PC.
        if (active && (state_q == S_DRAIN) && !ev_branch) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // Halt sequencing: RUN -> DRAIN on decoded halt, -> HALTED at WB.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (wb_halt)
                    state_d = S_HALTED;
                else if (ev_idle && id_halt)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wb_halt)
                    state_d = S_HALTED;
                else if (ev_branch)
                    state_d = S_RUN;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    // Saturating count of stall cycles.
    always_comb begin
        cnt_d = cnt_q;
        if ((ev_mwait || ev_hazard) && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    // State, halt flag and stall counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            halt_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_q == S_HALTED);
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign halt        = halt_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (default build, no forwarding).
// Stimulus pushes expected vectors; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, mem_dreq;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rt, id_halt;
    logic [4:0]  ex_rd;
    logic        ex_regWrite, ex_dren;
    logic [4:0]  mem_rd;
    logic        mem_regWrite, mem_pcsrc, wb_halt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic        halt;
    logic [1:0]  state;
    logic [15:0] stall_count;

    pipe_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dreq(mem_dreq), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_dren(ex_dren),
        .mem_rd(mem_rd), .mem_regWrite(mem_regWrite),
        .mem_pcsrc(mem_pcsrc), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halt(halt), .state(state), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
    localparam logic [8:0] C_RST   = 9'b001010101;
    localparam logic [8:0] C_NORM  = 9'b110101010;
    localparam logic [8:0] C_HALT  = 9'b000000000;
    localparam logic [8:0] C_MWAIT = 9'b000000011;
    localparam logic [8:0] C_BR    = 9'b111111110;
    localparam logic [8:0] C_HAZ   = 9'b000111010;
    localparam logic [8:0] C_FETCH = 9'b011101010;
    localparam logic [8:0] C_DRAIN = 9'b011101010;
    localparam logic [8:0] C_DRMW  = 9'b001000011;

    typedef struct {
        logic [8:0]  ctrl;
        logic [1:0]  st;
        logic        h;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   total = 0;
    int   passed = 0;
    logic [8:0] ctrl_o;

    assign ctrl_o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, exmem_flush, memwb_en, memwb_flush};

    // Monitor: compare every cycle that has an expected vector queued.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            total++;
            if (ctrl_o === m.ctrl && state === m.st &&
                halt === m.h && stall_count === m.cnt)
                passed++;
            else
                $display("FAIL %s: got ctrl=%b st=%0d halt=%b cnt=%h, need ctrl=%b st=%0d halt=%b cnt=%h",
                         m.name, ctrl_o, state, halt, stall_count,
                         m.ctrl, m.st, m.h, m.cnt);
        end
    end

    task automatic idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_dreq = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_halt = 1'b0;
        ex_rd = 5'd0; ex_regWrite = 1'b0; ex_dren = 1'b0;
        mem_rd = 5'd0; mem_regWrite = 1'b0; mem_pcsrc = 1'b0;
        wb_halt = 1'b0;
    endtask

    task automatic hz_ex();
        ex_rd = 5'd2; ex_regWrite = 1'b1; id_rs = 5'd2;
    endtask

    task automatic chk(input logic [8:0] c, input logic [1:0] s,
                       input logic h, input logic [15:0] n, input string nm);
        exp_t e;
        e.ctrl = c; e.st = s; e.h = h; e.cnt = n; e.name = nm;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk(C_RST, 2'd0, 1'b0, 16'd0, "reset");

        idle(); chk(C_NORM, 2'd0, 1'b0, 16'd0, "run_idle");
        idle(); hz_ex(); chk(C_HAZ, 2'd0, 1'b0, 16'd0, "haz_ex");
        idle(); mem_rd = 5'd2; mem_regWrite = 1'b1; id_rs = 5'd2;
        chk(C_HAZ, 2'd0, 1'b0, 16'd1, "haz_mem");
        idle(); mem_rd = 5'd3; mem_regWrite = 1'b1; id_rs = 5'd1;
        id_rt = 5'd3; chk(C_NORM, 2'd0, 1'b0, 16'd2, "rt_unused");
        idle(); mem_rd = 5'd3; mem_regWrite = 1'b1; id_rs = 5'd1;
        id_rt = 5'd3; id_uses_rt = 1'b1;
        chk(C_HAZ, 2'd0, 1'b0, 16'd2, "rt_used");
        idle(); ex_rd = 5'd0; ex_regWrite = 1'b1; id_rs = 5'd0;
        chk(C_NORM, 2'd0, 1'b0, 16'd3, "rd_zero");
        idle(); ihit = 1'b0; chk(C_FETCH, 2'd0, 1'b0, 16'd3, "fetch_wait");

        for (int i = 0; i < 3; i++) begin
            idle(); mem_dreq = 1'b1; dhit = 1'b0; mem_pcsrc = 1'b1;
            chk(C_MWAIT, 2'd0, 1'b0, 16'(3 + i), "mwait_br");
        end
        idle(); mem_dreq = 1'b1; mem_pcsrc = 1'b1;
        chk(C_BR, 2'd0, 1'b0, 16'd6, "br_after_dhit");
        idle(); hz_ex(); ihit = 1'b0;
        chk(C_HAZ, 2'd0, 1'b0, 16'd6, "haz_over_fetch");

        idle(); id_halt = 1'b1; chk(C_NORM, 2'd0, 1'b0, 16'd7, "id_halt");
        idle(); chk(C_DRAIN, 2'd1, 1'b0, 16'd7, "drain");
        idle(); mem_pcsrc = 1'b1;
        chk(C_BR, 2'd1, 1'b0, 16'd7, "drain_branch");
        idle(); chk(C_NORM, 2'd0, 1'b0, 16'd7, "back_to_run");
        idle(); id_halt = 1'b1; hz_ex();
        chk(C_HAZ, 2'd0, 1'b0, 16'd7, "halt_blocked");
        idle(); id_halt = 1'b1; chk(C_NORM, 2'd0, 1'b0, 16'd8, "id_halt2");
        idle(); mem_dreq = 1'b1; dhit = 1'b0;
        chk(C_DRMW, 2'd1, 1'b0, 16'd8, "drain_mwait");
        idle(); wb_halt = 1'b1; chk(C_DRAIN, 2'd1, 1'b0, 16'd9, "wb_halt");
        idle(); chk(C_HALT, 2'd2, 1'b0, 16'd9, "halted_0");
        idle(); chk(C_HALT, 2'd2, 1'b1, 16'd9, "halted_1");
        idle(); hz_ex(); chk(C_HALT, 2'd2, 1'b1, 16'd9, "halted_haz");
        idle(); RST = 1'b1; chk(C_RST, 2'd2, 1'b1, 16'd9, "rst_in_halt");
        idle(); chk(C_NORM, 2'd0, 1'b0, 16'd0, "after_rst");

        idle(); hz_ex();
        repeat (70000) @(posedge CLK);
        #1;
        chk(C_HAZ, 2'd0, 1'b0, 16'hFFFF, "sat_haz");
        idle(); chk(C_NORM, 2'd0, 1'b0, 16'hFFFF, "sat_hold");
        idle(); wb_halt = 1'b1;
        chk(C_NORM, 2'd0, 1'b0, 16'hFFFF, "run_wb_halt");
        idle(); chk(C_HALT, 2'd2, 1'b0, 16'hFFFF, "sat_halted0");
        idle(); chk(C_HALT, 2'd2, 1'b1, 16'hFFFF, "sat_halted1");
        idle(); RST = 1'b1; wb_halt = 1'b1;
        chk(C_RST, 2'd2, 1'b1, 16'hFFFF, "sat_rst");
        idle(); chk(C_NORM, 2'd0, 1'b0, 16'd0, "sat_cleared");

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge CLK);
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain_queue: %0d left, need 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: CLK in 1, pipeline clock, all state changes on rising edge.
REQ-002 SHALL have RST in 1, synchronous, active-high reset.
REQ-003 SHALL have inputs ihit 1 (fetch done), dhit 1 (data access done), mem_dreq 1 (MEM-stage instr has dren|dwen).
REQ-004 SHALL have inputs id_rs 5, id_rt 5, id_uses_rt 1, id_halt 1: decode-stage sources and decoded halt.
REQ-005 SHALL have inputs ex_rd 5, ex_regWrite 1, ex_dren 1 (ID/EX stage); mem_rd 5, mem_regWrite 1; mem_pcsrc 1 (branch/jump taken, resolved in MEM); wb_halt 1.
REQ-006 SHALL have outputs pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush (1 each); flush overrides en at the register.
REQ-007 SHALL have outputs halt 1 (registered), state 2 (RUN=0, DRAIN=1, HALTED=2), stall_count 16.

Function
REQ-008 All enable/flush outputs SHALL be combinational from state and current inputs (zero-cycle latency).
REQ-009 Default (RUN, no event): all *_en=1, all *_flush=0.
REQ-010 Priority, highest first: HALTED, memory wait, taken branch, data hazard, fetch wait.
REQ-011 Memory wait (mem_dreq & !dhit): pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1.
REQ-012 Taken branch (mem_pcsrc, no memory wait): pc_en=1, ifid_flush=idex_flush=exmem_flush=1.
REQ-013 Data hazard: pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance.
REQ-014 Hazard match SHALL require rd!=0 and (rd==id_rs or (id_uses_rt and rd==id_rt)).
REQ-015 Fetch wait (!ihit): pc_en=0, ifid_flush=1; later stages advance.
REQ-016 RUN->DRAIN when id_halt and cycle not blocked by memory wait/branch/hazard.
REQ-017 DRAIN: pc_en=0, ifid_flush=1, later stages per REQ-011..013; DRAIN->RUN on mem_pcsrc (older branch taken, flush per REQ-012).
REQ-018 DRAIN or RUN -> HALTED when wb_halt; HALTED sets halt=1 next edge, all *_en=0, flushes 0, until RST.
REQ-019 stall_count SHALL increment on every cycle with memory wait or data hazard, saturating at 0xFFFF.

Reset
REQ-020 While RST=1: all *_en=0, all *_flush=1, pc_en=0.
REQ-021 At edge with RST=1: state=RUN, halt=0, stall_count=0; RST overrides any concurrent event, including HALTED.

Configuration
REQ-022 Macro PIPE_FWD_EN SHALL select hazard detection.
REQ-023 Defined: hazard only for load-use (ex_dren & ex_regWrite & match on ex_rd); one bubble per load.
REQ-024 Undefined: hazard on match with ex_rd (ex_regWrite) or mem_rd (mem_regWrite); WB writes need no stall (register file writes first half-cycle).

Verification
REQ-025 lw $2 in EX, decode add rs=$2, PIPE_FWD_EN defined -> one cycle pc_en=0, idex_flush=1; stall_count 0->1.
REQ-026 Same without PIPE_FWD_EN, add $2 in EX then MEM -> two stall cycles; rd=$0 match -> no stall.
REQ-027 mem_dreq=1, dhit=0 for 3 cycles, mem_pcsrc=1 throughout -> 3 cycles full freeze plus memwb_flush, then flush cycle on dhit.
REQ-028 id_halt then mem_pcsrc in DRAIN -> state RUN, three flushes; halt later reaches WB -> HALTED, halt=1 next cycle.
REQ-029 RST asserted while HALTED with stall_count=0xFFFF -> state RUN, halt=0, count 0 after one edge.
REQ-030 Force 70000 hazard cycles -> stall_count holds 0xFFFF.
